// File: rtl/clock_input_ctrl_if.sv
// Raw panel inputs and conditioned single-cycle enables exchanged with clock_input_ctrl.
// The panel/environment side uses master, the conditioning block uses slave.
interface clock_input_ctrl_if;
    logic       run_sw;
    logic       btn_mode;
    logic       btn_up;
    logic       sec_tick;
    logic       inc_hr;
    logic       inc_min;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output run_sw, btn_mode, btn_up,
        input  sec_tick, inc_hr, inc_min, mode, blink
    );

    modport slave (
        input  run_sw, btn_mode, btn_up,
        output sec_tick, inc_hr, inc_min, mode, blink
    );
endinterface

// File: rtl/clock_input_ctrl.sv
// Input conditioning and time base for the 12-hour clock core: synchronize and debounce
// the switch and buttons, run the RUN/SET_HR/SET_MIN mode machine, and emit tick/increment/blink.
module clock_input_ctrl #(
    parameter int TICK_DIV     = 10_000_000,
    parameter int DB_CYCLES    = 200_000,
    parameter int REPEAT_DELAY = 5_000_000,
    parameter int REPEAT_RATE  = 2_500_000,
    parameter int BLINK_HALF   = 2_500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    clock_input_ctrl_if.slave bus
);

    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W     = $clog2(DB_CYCLES + 1);
    localparam int REP_SPAN = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W    = (REP_SPAN > 1) ? $clog2(REP_SPAN) : 1;
    localparam int BLINK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES);
    localparam logic [REP_W-1:0]   DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0]   RATE_LAST  = REP_W'(REPEAT_RATE - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_t;

    logic [2:0]           raw_in;
    logic [2:0]           sync_a;
    logic [2:0]           sync_b;
    logic [2:0]           level;
    logic [2:0][DB_W-1:0] db_cnt;
    logic [1:0]           btn_prev;

    logic                 run_level;
    logic                 up_level;
    logic                 mode_press;
    logic                 up_press;

    mode_t                state;
    logic                 in_set;

    logic [TICK_W-1:0]    pre_cnt;
    logic                 sec_tick_q;

    logic [REP_W-1:0]     rep_cnt;
    logic                 rep_active;
    logic                 rep_first;
    logic                 rep_due;
    logic                 hold_ok;
    logic                 fire;
    logic                 inc_hr_q;
    logic                 inc_min_q;

    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink_q;

    // Bit 0 = run switch, bit 1 = mode button, bit 2 = up button.
    assign raw_in = {bus.btn_up, bus.btn_mode, bus.run_sw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
        end
    end

    // A new level is accepted only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= '0;
        end else begin
            btn_prev <= level[2:1];
        end
    end

    assign run_level  = level[0];
    assign up_level   = level[2];
    assign mode_press = level[1] & ~btn_prev[0];
    assign up_press   = level[2] & ~btn_prev[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MODE_RUN;
        end else if (mode_press) begin
            case (state)
                MODE_RUN:    state <= MODE_SET_HR;
                MODE_SET_HR: state <= MODE_SET_MIN;
                default:     state <= MODE_RUN;
            endcase
        end
    end

    assign in_set = (state == MODE_SET_HR) || (state == MODE_SET_MIN);

    // Leaving RUN discards any partial second so setting always restarts a clean second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= 1'b0;
            if ((state != MODE_RUN) || mode_press) begin
                pre_cnt <= '0;
            end else if (run_level) begin
                if (pre_cnt == TICK_LAST) begin
                    pre_cnt    <= '0;
                    sec_tick_q <= 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rep_due = 1'b0;
        if (rep_active) begin
            rep_due = (rep_cnt == (rep_first ? DELAY_LAST : RATE_LAST));
        end
    end

    // A mode press or a release disarms repeat; only a fresh press re-arms it.
    assign hold_ok = in_set && up_level && !mode_press;
    assign fire    = hold_ok && (up_press || rep_due);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt    <= '0;
            rep_active <= 1'b0;
            rep_first  <= 1'b0;
            inc_hr_q   <= 1'b0;
            inc_min_q  <= 1'b0;
        end else begin
            inc_hr_q  <= fire && (state == MODE_SET_HR);
            inc_min_q <= fire && (state == MODE_SET_MIN);
            if (!hold_ok) begin
                rep_cnt    <= '0;
                rep_active <= 1'b0;
                rep_first  <= 1'b0;
            end else if (up_press) begin
                rep_cnt    <= '0;
                rep_active <= 1'b1;
                rep_first  <= 1'b1;
            end else if (rep_due) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else if (rep_active) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (mode_press || !in_set) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign bus.sec_tick = sec_tick_q;
    assign bus.inc_hr   = inc_hr_q;
    assign bus.inc_min  = inc_min_q;
    assign bus.mode     = state;
    assign bus.blink    = blink_q;

endmodule

// File: doc/clock_input_ctrl.md
# clock_input_ctrl

Front-end conditioning and time-base block placed directly upstream of the 12-hour digital clock core. It synchronizes and debounces the raw run switch and the two user push-buttons, runs a mode state machine (run / set-hours / set-minutes), and produces single-cycle enables for the core:
- a one-second tick,
- hour and minute increment pulses with auto-repeat,
- a blink strobe for the digit being set.

## Interface
Parameters:
- TICK_DIV, 10_000_000: clk cycles per sec_tick (≥2)
- DB_CYCLES, 200_000: consecutive equal synchronized samples needed to accept a new debounced level (≥1)
- REPEAT_DELAY, 5_000_000: cycles from first increment pulse to first auto-repeat pulse while btn_up is held
- REPEAT_RATE, 2_500_000: cycles between subsequent auto-repeat pulses
- BLINK_HALF, 2_500_000: half-period of blink, in cycles

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run_sw  in  1  raw run-enable switch, asynchronous, high = run
- btn_mode  in  1  raw mode button, asynchronous, high = pressed
- btn_up  in  1  raw increment button, asynchronous, high = pressed
- sec_tick  out  1  one-cycle pulse, once per second
- inc_hr  out  1  one-cycle hour-increment pulse
- inc_min  out  1  one-cycle minute-increment pulse
- mode  out  2  0 = RUN, 1 = SET_HR, 2 = SET_MIN (3 is never driven)
- blink  out  1  digit-visible strobe for the field being set

## Operation
- Each raw input passes through a 2-flop synchronizer and then a debouncer.
- Debouncer: counter cleared whenever the synchronized sample equals the current debounced level; otherwise it increments. When it reaches DB_CYCLES, the debounced level flips and the counter clears.
- Press event: a registered rising edge of the debounced button level. Releases produce no event.
- Mode FSM: RUN → SET_HR → SET_MIN → RUN, advancing on each btn_mode press event.
- Prescaler (width clog2(TICK_DIV)):
  - Counts only when mode == RUN and debounced run_sw == 1.
  - At TICK_DIV−1 it pulses sec_tick and wraps to 0.
  - It holds its value while run_sw is low in RUN.
  - It is cleared on every transition into SET_HR, and stays at 0 in set modes.
- btn_up press event:
  - In SET_HR: pulses inc_hr.
  - In SET_MIN: pulses inc_min.
  - In RUN: ignored.
- Auto-repeat:
  - While debounced btn_up stays high in a set mode, a repeat counter runs.
  - The first extra pulse comes REPEAT_DELAY cycles after the press pulse. Each later pulse comes REPEAT_RATE cycles after the previous one.
  - Pulses go to the output matching the current mode.
- blink:
  - Constant 1 in RUN.
  - In set modes it toggles every BLINK_HALF cycles. Its counter restarts with blink = 1 on every mode change.
- Simultaneous btn_mode and btn_up press events in the same cycle: the mode change wins and the btn_up event is discarded.
- Mode change while btn_up is held: the repeat counter clears. No increment pulses occur until btn_up is released and pressed again.
- Release of btn_up: repeat counter clears immediately. A pulse scheduled for that cycle is suppressed.
- At most one of sec_tick, inc_hr, inc_min is high in any cycle.

## Timing
- Reset (rst_n low, takes effect immediately, without waiting for a clock edge):
  - sec_tick = inc_hr = inc_min = 0, mode = 0, blink = 1.
  - All counters are cleared.
  - Synchronizers and debounced levels are set to 0.
- The first clk rising edge after rst_n deasserts is cycle 0.
- Button latency: a raw input held steady from the edge at cycle k changes its debounced level at edge k+2+DB_CYCLES.
  - The press event, and the resulting mode change or inc pulse, is visible after edge k+3+DB_CYCLES.
- sec_tick cadence: first pulse is high during the cycle after the TICK_DIV-th counting edge. After that it repeats exactly every TICK_DIV cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation (including mid-debounce, mid-repeat, or mid-prescale) aborts everything. After deassertion, operation restarts from RUN with nothing pending.

## Test plan
Bench parameters: TICK_DIV=10, DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, BLINK_HALF=8.
- Reset then run: hold run_sw = 1 from cycle 0 → sec_tick pulses 1 cycle wide at a fixed phase, exactly 10 cycles apart. mode = 0, blink = 1 throughout. Drop run_sw for 30 cycles → no ticks, and the phase resumes from the held count.
- Bounce rejection: toggle btn_mode every 3 cycles for 40 cycles, then hold high → exactly one mode advance (0 → 1), occurring 7 cycles after the final stable edge.
- Set hours with repeat: in SET_HR, hold btn_up for 40 cycles past debounce → inc_hr pulses at press+0, +20, +25, +30, +35. inc_min and sec_tick stay 0. blink toggles every 8 cycles starting high.
- Full mode cycle: three btn_mode presses → mode 1, 2, 0. In SET_MIN a single btn_up press gives exactly one inc_min. After returning to RUN, the first sec_tick arrives 10 counting cycles later.
- Collision: btn_mode and btn_up debounced-high on the same cycle in SET_HR → mode = 2, no inc_hr and no inc_min, and no repeat pulses while btn_up remains held.
- Reset mid-repeat: assert rst_n low asynchronously between clk edges during auto-repeat → all outputs reach their reset values before the next edge. After release: mode = 0 and no pulses for at least 9 cycles.
